// File: rtl/jelly3_fifo_sync_stream.sv
// ---------------------------------------------------------------------------
// jelly3_fifo_sync_stream
//   Single-clock FIFO with valid/ready stream ports and first-word-fall-through
//   output. Words are stored in a simple dual-port RAM (both ports on clk),
//   then prefetched through a short read pipeline into a small output queue
//   whose head register drives m_data. All status outputs are registered and
//   change on the same edge as the transfer that moves them.
//
//   Optional feature macro: JELLY3_FIFO_SYNC_STREAM_CLEAR_EN
//     defined   -> adds input 'clear' (synchronous flush, gated by cke)
//     undefined -> no clear port; contents discarded only by reset_n
//
// Ports
//   clk, reset_n (async, active low), cke (0 freezes everything)
//   s_data/s_valid/s_ready           write stream
//   s_free_size, s_almost_full       write-side status
//   m_data/m_valid/m_ready           read stream (first-word-fall-through)
//   m_data_size, m_almost_empty      read-side status
//   clear                            flush (only with the macro above)
// ---------------------------------------------------------------------------
module jelly3_fifo_sync_stream #(
  parameter int    PTR_BITS   = 5,
  parameter int    SIZE_BITS  = $clog2((2 ** PTR_BITS) + 1),
  parameter int    DATA_BITS  = 8,
  parameter string RAM_TYPE   = "block",
  parameter bit    DOUT_REG   = 1'b0,
  parameter int    AF_THRESH  = (2 ** PTR_BITS) - 2,
  parameter int    AE_THRESH  = 1,
  parameter string DEVICE     = "RTL",
  parameter string SIMULATION = "false",
  parameter string DEBUG      = "false"
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cke,
`ifdef JELLY3_FIFO_SYNC_STREAM_CLEAR_EN
  input  logic                 clear,
`endif
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [SIZE_BITS-1:0] s_free_size,
  output logic                 s_almost_full,
  output logic [DATA_BITS-1:0] m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [SIZE_BITS-1:0] m_data_size,
  output logic                 m_almost_empty
);

  localparam int FIFO_SIZE = 2 ** PTR_BITS;
  localparam int RD_LAT    = DOUT_REG ? 2 : 1;   // RAM read latency
  localparam int Q_DEPTH   = RD_LAT + 1;         // output queue slots

  typedef logic [SIZE_BITS-1:0] size_t;
  typedef logic [DATA_BITS-1:0] data_t;
  typedef logic [PTR_BITS:0]    ptr_t;

  // Elaboration-time parameter sanity.
  if (AF_THRESH < 1 || AF_THRESH > FIFO_SIZE) begin : g_bad_af
    $error("AF_THRESH out of range 1..FIFO_SIZE");
  end
  if (AE_THRESH < 0 || AE_THRESH > FIFO_SIZE - 1) begin : g_bad_ae
    $error("AE_THRESH out of range 0..FIFO_SIZE-1");
  end
  if (RAM_TYPE == "" || DEVICE == "") begin : g_bad_str
    $error("RAM_TYPE and DEVICE must be non-empty");
  end
  if ((SIMULATION != "true" && SIMULATION != "false") ||
      (DEBUG != "true" && DEBUG != "false")) begin : g_bad_flag
    $error("SIMULATION/DEBUG must be \"true\" or \"false\"");
  end

  logic w_clear;
`ifdef JELLY3_FIFO_SYNC_STREAM_CLEAR_EN
  assign w_clear = clear;
`else
  assign w_clear = 1'b0;
`endif

  // Control state
  ptr_t       r_wptr, r_rptr;       // rptr = next RAM address to prefetch
  logic       r_rv0, r_rv1;         // read-pipeline valid stages
  logic [1:0] r_q_cnt;              // words held in the output queue
  size_t      r_count, r_free;
  logic       r_s_ready, r_af, r_m_valid, r_ae;

  // Storage / datapath
  data_t      r_mem [0:FIFO_SIZE-1];
  data_t      r_rdata0, r_rdata1;
  data_t      r_q_data [0:3];       // head at index 0; only Q_DEPTH slots used

  logic       w_s_ready, w_push, w_pop, w_re, w_arr;
  data_t      w_arr_data;
  ptr_t       w_ram_cnt;
  logic [2:0] w_inflight;
  logic [1:0] w_q_cnt_next, w_q_idx;
  size_t      w_count_next;

  // s_ready is forced low during clear so a word offered then is dropped.
  assign w_s_ready  = r_s_ready & ~w_clear;
  assign w_push     = cke & s_valid & w_s_ready;
  assign w_pop      = cke & r_m_valid & m_ready & ~w_clear;

  assign w_ram_cnt  = r_wptr - r_rptr;
  assign w_inflight = 3'(r_rv0) + (DOUT_REG ? 3'(r_rv1) : 3'd0);

  // Prefetch whenever the RAM holds data and a queue slot will be free by the
  // time the read returns; counting this cycle's pop keeps 1 word/cycle.
  assign w_re = cke & ~w_clear & (w_ram_cnt != '0) &
                ((w_inflight + 3'(r_q_cnt)) < (3'(Q_DEPTH) + 3'(w_pop)));

  assign w_arr        = DOUT_REG ? r_rv1    : r_rv0;
  assign w_arr_data   = DOUT_REG ? r_rdata1 : r_rdata0;
  assign w_q_cnt_next = r_q_cnt + 2'(w_arr) - 2'(w_pop);
  assign w_q_idx      = r_q_cnt - 2'(w_pop);
  assign w_count_next = r_count + size_t'(w_push) - size_t'(w_pop);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_rv0     <= 1'b0;
      r_rv1     <= 1'b0;
      r_q_cnt   <= '0;
      r_count   <= '0;
      r_free    <= '0;
      r_s_ready <= 1'b0;
      r_af      <= 1'b0;
      r_m_valid <= 1'b0;
      r_ae      <= 1'b1;
    end else if (cke) begin
      if (w_clear) begin
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_rv0     <= 1'b0;
        r_rv1     <= 1'b0;
        r_q_cnt   <= '0;
        r_count   <= '0;
        r_free    <= size_t'(FIFO_SIZE);
        r_s_ready <= 1'b1;
        r_af      <= 1'b0;
        r_m_valid <= 1'b0;
        r_ae      <= 1'b1;
      end else begin
        if (w_push) r_wptr <= r_wptr + 1'b1;
        if (w_re)   r_rptr <= r_rptr + 1'b1;
        r_rv0     <= w_re;
        r_rv1     <= r_rv0;
        r_q_cnt   <= w_q_cnt_next;
        r_count   <= w_count_next;
        r_free    <= size_t'(FIFO_SIZE) - w_count_next;
        r_s_ready <= (w_count_next < size_t'(FIFO_SIZE));
        r_af      <= (w_count_next >= size_t'(AF_THRESH));
        r_m_valid <= (w_q_cnt_next != '0);
        r_ae      <= (w_count_next <= size_t'(AE_THRESH));
      end
    end
  end

  // NOTE: RAM and data registers carry no reset; the valid/count state above
  // decides what is meaningful, and an un-reset array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (cke) begin
      if (w_push) r_mem[r_wptr[PTR_BITS-1:0]] <= s_data;
      if (w_re)   r_rdata0 <= r_mem[r_rptr[PTR_BITS-1:0]];
      r_rdata1 <= r_rdata0;
      if (w_pop) begin
        for (int i = 0; i < 3; i++) r_q_data[i] <= r_q_data[i+1];
      end
      // Arriving word lands behind the survivors (overrides the shift).
      if (w_arr) r_q_data[w_q_idx] <= w_arr_data;
    end
  end

  assign s_ready        = w_s_ready;
  assign s_free_size    = r_free;
  assign s_almost_full  = r_af;
  assign m_data         = r_q_data[0];
  assign m_valid        = r_m_valid;
  assign m_data_size    = r_count;
  assign m_almost_empty = r_ae;

endmodule

// File: tb/tb_jelly3_fifo_sync_stream.sv
// Self-checking bench for jelly3_fifo_sync_stream. Two instances (DOUT_REG=0
// and DOUT_REG=1, PTR_BITS=4) share stimulus; each is compared every cycle
// against a behavioural model: a circular list of (word, push edge) with the
// rule "head is visible once push_edge + 1 + latency edges have passed".
module tb_jelly3_fifo_sync_stream;
  localparam int N = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic cke = 1'b0;
  logic clear = 1'b0;
  logic s_valid = 1'b0;
  logic m_ready = 1'b0;
  logic [7:0] s_data = '0;

  logic       s_ready_w [2];
  logic [4:0] free_w    [2];
  logic       af_w      [2];
  logic [7:0] m_data_w  [2];
  logic       m_valid_w [2];
  logic [4:0] size_w    [2];
  logic       ae_w      [2];

  always #5 clk = ~clk;

  jelly3_fifo_sync_stream #(.PTR_BITS(4), .DATA_BITS(8), .DOUT_REG(1'b0)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .cke(cke),
`ifdef JELLY3_FIFO_SYNC_STREAM_CLEAR_EN
    .clear(clear),
`endif
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_w[0]),
    .s_free_size(free_w[0]), .s_almost_full(af_w[0]),
    .m_data(m_data_w[0]), .m_valid(m_valid_w[0]), .m_ready(m_ready),
    .m_data_size(size_w[0]), .m_almost_empty(ae_w[0]));

  jelly3_fifo_sync_stream #(.PTR_BITS(4), .DATA_BITS(8), .DOUT_REG(1'b1)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .cke(cke),
`ifdef JELLY3_FIFO_SYNC_STREAM_CLEAR_EN
    .clear(clear),
`endif
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready_w[1]),
    .s_free_size(free_w[1]), .s_almost_full(af_w[1]),
    .m_data(m_data_w[1]), .m_valid(m_valid_w[1]), .m_ready(m_ready),
    .m_data_size(size_w[1]), .m_almost_empty(ae_w[1]));

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model state, per instance
  int         cnt [2];
  int         head [2];
  int         ecyc [2];      // cke edges since reset
  bit         started [2];   // at least one cke edge since reset
  logic [7:0] md [2][N];
  int         mt [2][N];

  typedef struct {
    logic       s_valid;
    logic [7:0] s_data;
    logic       m_ready;
    logic       exp_ready;
    logic [4:0] exp_free;
    logic       exp_af;
    logic [4:0] exp_size;
  } vec_t;
  vec_t tbl [18];

  task automatic check(input string name, input int i,
                       input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s dut%0d: got %0h expected %0h (t=%0t)", name, i, act, exp, $time);
    end
  endtask

  function automatic bit mvalid(input int i);
    return (cnt[i] > 0) && (mt[i][head[i]] + 1 + (i + 1) <= ecyc[i]);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      cnt[i] = 0; head[i] = 0; ecyc[i] = 0; started[i] = 1'b0;
    end
  endtask

  task automatic model_step();
    if (!reset_n || !cke) return;
    for (int i = 0; i < 2; i++) begin
      bit rdy, pop;
      rdy = started[i] && (cnt[i] < N) && !clear;
      pop = mvalid(i) && m_ready;
      ecyc[i]++;
      if (clear) begin
        cnt[i] = 0; head[i] = 0;
      end else begin
        if (pop) begin head[i] = (head[i] + 1) % N; cnt[i]--; end
        if (rdy && s_valid) begin
          md[i][(head[i] + cnt[i]) % N] = s_data;
          mt[i][(head[i] + cnt[i]) % N] = ecyc[i];
          cnt[i]++;
        end
      end
      started[i] = 1'b1;
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      check("s_ready", i, s_ready_w[i], started[i] && cnt[i] < N && !clear);
      check("s_free_size", i, free_w[i], started[i] ? N - cnt[i] : 0);
      check("s_almost_full", i, af_w[i], cnt[i] >= 14);
      check("m_data_size", i, size_w[i], cnt[i]);
      check("m_almost_empty", i, ae_w[i], cnt[i] <= 1);
      check("m_valid", i, m_valid_w[i], mvalid(i));
      if (mvalid(i)) check("m_data", i, m_data_w[i], md[i][head[i]]);
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge;
  // the caller then drives the next inputs.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    int hs [2];
    int first [2];
    int sent, cyc;
    bit got;

    // ---- reset state --------------------------------------------------
    model_reset();
    cke = 1'b1;
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) check("ready_after_release", i, s_ready_w[i], 1);

    // ---- fill to full with m_ready low (table-driven) ------------------
    for (int j = 0; j < 18; j++) begin
      int sz;
      sz = (j + 1 > N) ? N : j + 1;
      tbl[j].s_valid   = 1'b1;
      tbl[j].s_data    = 8'(j);
      tbl[j].m_ready   = 1'b0;
      tbl[j].exp_ready = (sz < N);
      tbl[j].exp_free  = 5'(N - sz);
      tbl[j].exp_af    = (sz >= 14);
      tbl[j].exp_size  = 5'(sz);
    end
    for (int j = 0; j < 18; j++) begin
      s_valid = tbl[j].s_valid; s_data = tbl[j].s_data; m_ready = tbl[j].m_ready;
      tick();
      for (int i = 0; i < 2; i++) begin
        check("tbl_s_ready", i, s_ready_w[i], tbl[j].exp_ready);
        check("tbl_free", i, free_w[i], tbl[j].exp_free);
        check("tbl_af", i, af_w[i], tbl[j].exp_af);
        check("tbl_size", i, size_w[i], tbl[j].exp_size);
      end
    end

    // ---- full: pop and push offered together ----------------------------
    s_valid = 1'b1; s_data = 8'hA0; m_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check("full_head", i, m_data_w[i], 8'h00);
      check("full_ready", i, s_ready_w[i], 0);
    end
    tick();
    for (int i = 0; i < 2; i++) begin
      check("full_pop_size", i, size_w[i], 15);
      check("full_pop_ready", i, s_ready_w[i], 1);
    end
    tick();
    for (int i = 0; i < 2; i++) check("push_pop_size", i, size_w[i], 15);
    s_valid = 1'b0;
    repeat (25) tick();
    for (int i = 0; i < 2; i++) check("drained", i, size_w[i], 0);

    // ---- reset mid-stream with 10 words stored --------------------------
    m_ready = 1'b0; s_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      s_data = 8'(8'h30 + k);
      tick();
    end
    s_valid = 1'b0;
    reset_n = 1'b0;
    model_reset();
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_m_valid", i, m_valid_w[i], 0);
      check("rst_size", i, size_w[i], 0);
      check("rst_s_ready", i, s_ready_w[i], 0);
    end
    check_all();
    tick();
    reset_n = 1'b1;
    tick();
    for (int i = 0; i < 2; i++) check("rst_ready_rise", i, s_ready_w[i], 1);

    // ---- continuous 100-word stream -------------------------------------
    sent = 0; hs = '{0, 0}; first = '{-1, -1};
    m_ready = 1'b1;
    for (int t = 1; t <= 140; t++) begin
      s_valid = (sent < 100); s_data = 8'(sent);
      for (int i = 0; i < 2; i++) if (m_valid_w[i]) hs[i]++;
      tick();
      if (s_valid) sent++;
      for (int i = 0; i < 2; i++) if (first[i] < 0 && m_valid_w[i]) first[i] = t;
    end
    s_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("first_valid_tick", i, first[i], i + 3);
      check("stream_words", i, hs[i], 100);
    end

    // ---- random traffic, 10k words --------------------------------------
    hs = '{0, 0}; cyc = 0;
    while ((hs[0] < 10000 || hs[1] < 10000) && cyc < 40000) begin
      cke     = ($urandom_range(7) != 0);
      s_valid = $urandom_range(1);
      m_ready = $urandom_range(1);
      s_data  = 8'($urandom);
      for (int i = 0; i < 2; i++) if (cke && m_ready && m_valid_w[i]) hs[i]++;
      tick();
      cyc++;
    end
    cke = 1'b1;
    for (int i = 0; i < 2; i++) check("random_words_done", i, hs[i] >= 10000, 1);

`ifdef JELLY3_FIFO_SYNC_STREAM_CLEAR_EN
    // ---- clear with a push offered in the same cycle --------------------
    s_valid = 1'b0; m_ready = 1'b1;
    repeat (40) tick();
    m_ready = 1'b0; s_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      s_data = 8'(8'h60 + k);
      tick();
    end
    clear = 1'b1; s_data = 8'hEE; m_ready = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) check("clr_ready_low", i, s_ready_w[i], 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      check("clr_size", i, size_w[i], 0);
      check("clr_m_valid", i, m_valid_w[i], 0);
    end
    clear = 1'b0; s_data = 8'h01; m_ready = 1'b0;
    tick();
    s_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      got = 1'b0;
      for (int w = 0; w < 10 && !got; w++) begin
        if (m_valid_w[i]) got = 1'b1;
        else tick();
      end
      check("clr_valid_timeout", i, got, 1);
      check("clr_first_word", i, m_data_w[i], 8'h01);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
